mem_wr_buffer: RTL and testbench

MEM_WR_BUFFER -- requirements
Module: mem_wr_buffer

---
 rtl/mem_wr_buffer.sv | 148 ++++++++++++++
 tb/tb_mem_wr_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wr_buffer.sv
// mem_wr_buffer: small posted-write queue in front of a memory write port.
//   Accepts word writes (in_valid/in_ready), drops requests outside the
//   memory window [OFFSET, OFFSET+DEPTH-1] and flags them (err/err_count).
//   Queued writes drain one per cycle to mem_* unless hold is asserted.
//   rd_data forwards the newest queued write matching rd_addr, otherwise
//   mem_rdata.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake; in_addr/in_data payload
//   hold                      drain inhibit
//   mem_wen/mem_waddr/wdata   memory write port (head of queue)
//   rd_addr, mem_rdata        read address / async memory read data
//   rd_data                   read data with pending-write forwarding
//   count                     entries queued
//   err, err_count            drop pulse, saturating drop counter
module mem_wr_buffer #(
  parameter int WIDTH  = 80,
  parameter int AWIDTH = 6,
  parameter int OFFSET = 32,
  parameter int DEPTH  = 32,
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [AWIDTH-1:0]       in_addr,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    hold,
  output logic                    mem_wen,
  output logic [AWIDTH-1:0]       mem_waddr,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [AWIDTH-1:0]       rd_addr,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(QDEPTH):0] count,
  output logic                    err,
  output logic [7:0]              err_count
);

  localparam int PW  = $clog2(QDEPTH);
  localparam int CW  = PW + 1;
  localparam int AW1 = AWIDTH + 1;
  // One extra bit so OFFSET+DEPTH-1 cannot wrap.
  localparam logic [AWIDTH:0] WIN_LO = AW1'(OFFSET);
  localparam logic [AWIDTH:0] WIN_HI = AW1'(OFFSET + DEPTH - 1);

  logic [AWIDTH-1:0] addr_mem_q [QDEPTH];
  logic [AWIDTH-1:0] addr_mem_d [QDEPTH];
  logic [WIDTH-1:0]  data_mem_q [QDEPTH];
  logic [WIDTH-1:0]  data_mem_d [QDEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              err_q, err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [AWIDTH-1:0] last_addr_q, last_addr_d;
  logic [WIDTH-1:0]  last_data_q, last_data_d;

  logic              push_req;
  logic              in_win;
  logic              push;
  logic              pop;
  logic [AWIDTH:0]   in_addr_ext;
  logic [PW-1:0]     fwd_idx;

  assign in_addr_ext = {1'b0, in_addr};
  assign in_win      = (in_addr_ext >= WIN_LO) && (in_addr_ext <= WIN_HI);

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign in_ready = (count_q < CW'(QDEPTH));
  assign push_req = in_valid && in_ready && !rst;
  assign push     = push_req && in_win;
  assign mem_wen  = !rst && (count_q != '0) && !hold;
  assign pop      = mem_wen;

  assign count     = count_q;
  assign err       = err_q;
  assign err_count = err_cnt_q;

  // Head entry while non-empty, otherwise the last values written out.
  assign mem_waddr = (count_q != '0) ? addr_mem_q[rd_ptr_q] : last_addr_q;
  assign mem_wdata = (count_q != '0) ? data_mem_q[rd_ptr_q] : last_data_q;

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = in_addr;
      data_mem_d[wr_ptr_q] = in_data;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    err_d       = push_req && !in_win;
    err_cnt_d   = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    last_addr_d = pop ? addr_mem_q[rd_ptr_q] : last_addr_q;
    last_data_d = pop ? data_mem_q[rd_ptr_q] : last_data_q;
  end

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    rd_data = mem_rdata;
    fwd_idx = rd_ptr_q;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem_q[fwd_idx] == rd_addr)) begin
        rd_data = data_mem_q[fwd_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    addr_mem_q <= addr_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: tb/tb_mem_wr_buffer.sv
module tb_mem_wr_buffer;
  localparam int WIDTH  = 80;
  localparam int AWIDTH = 6;
  localparam int OFFSET = 32;
  localparam int DEPTH  = 32;
  localparam int QDEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [AWIDTH-1:0] in_addr = '0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              hold = 1'b0;
  logic              mem_wen;
  logic [AWIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [AWIDTH-1:0] rd_addr = '0;
  logic [WIDTH-1:0]  mem_rdata = '0;
  logic [WIDTH-1:0]  rd_data;
  logic [2:0]        count;
  logic              err;
  logic [7:0]        err_count;

  typedef struct {
    logic [AWIDTH-1:0] a;
    logic [WIDTH-1:0]  d;
  } ent_t;

  // pend: what the buffer should currently hold; exp_q: writes still owed.
  ent_t pend[$];
  ent_t exp_q[$];
  bit   m_err;
  int   m_errcnt;
  ent_t m_last;
  bit   m_last_v;

  int checks = 0;
  int errors = 0;

  mem_wr_buffer #(
    .WIDTH(WIDTH), .AWIDTH(AWIDTH), .OFFSET(OFFSET), .DEPTH(DEPTH), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .rd_addr(rd_addr),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .count(count), .err(err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_data();
    return WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Reference model: a plain FIFO of accepted in-window writes.
  always @(posedge clk) begin
    int   sz;
    bit   do_pop;
    bit   do_push;
    ent_t e;
    sz = pend.size();
    if (rst) begin
      pend.delete();
      exp_q.delete();
      m_err    = 1'b0;
      m_errcnt = 0;
      m_last_v = 1'b0;
    end else begin
      do_pop  = (sz != 0) && !hold;
      do_push = in_valid && (sz < QDEPTH);
      m_err   = 1'b0;
      if (do_pop) begin
        m_last   = pend.pop_front();
        m_last_v = 1'b1;
      end
      if (do_push) begin
        if (int'(in_addr) >= OFFSET && int'(in_addr) <= OFFSET + DEPTH - 1) begin
          e.a = in_addr;
          e.d = in_data;
          pend.push_back(e);
          exp_q.push_back(e);
        end else begin
          m_err = 1'b1;
          if (m_errcnt < 255) m_errcnt++;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the clock edge.
  always @(negedge clk) begin
    bit               ew;
    logic [WIDTH-1:0] erd;
    ent_t             h;
    ew = !rst && (pend.size() != 0) && !hold;
    chk("mem_wen", WIDTH'(mem_wen), WIDTH'(ew));
    chk("count", WIDTH'(count), WIDTH'(pend.size()));
    chk("in_ready", WIDTH'(in_ready), WIDTH'(pend.size() < QDEPTH));
    chk("err", WIDTH'(err), WIDTH'(m_err));
    chk("err_count", WIDTH'(err_count), WIDTH'(m_errcnt));
    erd = mem_rdata;
    foreach (pend[i]) if (pend[i].a == rd_addr) erd = pend[i].d;
    chk("rd_data", rd_data, erd);
    if (mem_wen) begin
      chk("write_expected", WIDTH'(exp_q.size() != 0), WIDTH'(1));
      if (exp_q.size() != 0) begin
        h = exp_q.pop_front();
        chk("mem_waddr", WIDTH'(mem_waddr), WIDTH'(h.a));
        chk("mem_wdata", mem_wdata, h.d);
      end
    end else if (pend.size() != 0) begin
      chk("idle_waddr_head", WIDTH'(mem_waddr), WIDTH'(pend[0].a));
      chk("idle_wdata_head", mem_wdata, pend[0].d);
    end else if (m_last_v) begin
      chk("idle_waddr_last", WIDTH'(mem_waddr), WIDTH'(m_last.a));
      chk("idle_wdata_last", mem_wdata, m_last.d);
    end
  end

  task automatic step(input bit v, input int a, input logic [WIDTH-1:0] d, input bit h,
                      input int rd = -1);
    in_valid  = v;
    in_addr   = AWIDTH'(a);
    in_data   = d;
    hold      = h;
    rd_addr   = (rd < 0) ? AWIDTH'($urandom_range(32, 39)) : AWIDTH'(rd);
    mem_rdata = rnd_data();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit h);
    for (int i = 0; i < n; i++) step(1'b0, 0, '0, h);
  endtask

  initial begin
    logic [WIDTH-1:0] d5;
    int               a;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1, 1'b0);

    // single write
    step(1'b1, 40, WIDTH'(80'h1234), 1'b0);
    idle(3, 1'b0);

    // fill and backpressure, then release
    for (int i = 0; i < 4; i++) step(1'b1, 32 + i, rnd_data(), 1'b1);
    d5 = rnd_data();
    step(1'b1, 36, d5, 1'b1);
    step(1'b1, 36, d5, 1'b1);
    step(1'b1, 36, d5, 1'b0);
    step(1'b1, 36, d5, 1'b0);
    idle(6, 1'b0);

    // out-of-window drops and saturation
    step(1'b1, 5, rnd_data(), 1'b0);
    step(1'b1, 31, rnd_data(), 1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, $urandom_range(0, 31), rnd_data(), 1'b0);
    idle(2, 1'b0);

    // forwarding: newest match wins
    step(1'b1, 50, rnd_data(), 1'b1, 50);
    step(1'b1, 50, rnd_data(), 1'b1, 50);
    step(1'b0, 0, '0, 1'b1, 50);
    step(1'b0, 0, '0, 1'b1, 51);
    for (int i = 0; i < 4; i++) step(1'b0, 0, '0, 1'b0, 50);

    // streaming push/pop
    for (int i = 0; i < 10; i++) step(1'b1, 32 + i, rnd_data(), 1'b0);
    idle(3, 1'b0);

    // reset mid-drain
    for (int i = 0; i < 3; i++) step(1'b1, 33 + i, rnd_data(), 1'b1);
    rst = 1'b1;
    step(1'b1, 40, rnd_data(), 1'b1);
    rst = 1'b0;
    idle(4, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a   = ($urandom_range(0, 4) != 0) ? int'($urandom_range(32, 39)) : int'($urandom_range(0, 63));
      rst = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, a, rnd_data(), $urandom_range(0, 3) == 0,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : -1);
      rst = 1'b0;
    end

    idle(8, 1'b0);
    chk("scoreboard_empty", WIDTH'(exp_q.size()), WIDTH'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
